// File: rtl/riscv_fetch_ctrl.sv
// riscv_fetch_ctrl: PC register, next-PC select, IF/ID register, halt FSM.
// Ports: i_clk/i_rst, fetch pc/imem/adder, hazard stall/flush, ex redirect,
//   halt/resume, IF/ID outputs, o_halted, o_misalign_e, o_fetch_cnt.
module riscv_fetch_ctrl #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic [XLEN-1:0] o_pc_f,
  input  logic [XLEN-1:0] i_im_rd_f,
  input  logic [XLEN-1:0] i_pc_plus_4_f,
  input  logic            i_stall_f,
  input  logic            i_stall_d,
  input  logic            i_flush_d,
  input  logic            i_pc_src_e,
  input  logic [XLEN-1:0] i_pc_target_e,
  input  logic            i_halt,
  input  logic            i_resume,
  output logic [XLEN-1:0] o_instr_d,
  output logic [XLEN-1:0] o_pc_d,
  output logic [XLEN-1:0] o_pc_plus_4_d,
  output logic            o_valid_d,
  output logic            o_halted,
  output logic            o_misalign_e,
  output logic [31:0]     o_fetch_cnt
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } if_id_t;

  localparam if_id_t BUBBLE = '{
    instr: NOP_INSTR,
    pc:    '0,
    pc4:   '0,
    valid: 1'b0
  };

  state_t          state_q, state_n;
  logic [XLEN-1:0] pc_q, pc_n;
  if_id_t          ifid_q, ifid_n;
  logic            mis_q, mis_n;
  logic [31:0]     cnt_q, cnt_n;
  logic            redir;
  logic            frozen;
  logic            load;

  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    ifid_n  = ifid_q;
    mis_n   = 1'b0;
    load    = 1'b0;
    // a redirect during BOOT is dropped; elsewhere it beats every hold
    redir   = i_pc_src_e && (state_q != S_BOOT);
    frozen  = (state_q != S_RUN);

    unique case (state_q)
      S_BOOT: state_n = S_RUN;
      S_RUN: begin
        if (i_halt && !i_pc_src_e) state_n = S_HALT;
      end
      S_HALT: begin
        if (i_resume && !i_halt) state_n = S_RUN;
      end
      default: state_n = S_BOOT;
    endcase

    if (redir) begin
      pc_n  = {i_pc_target_e[XLEN-1:2], 2'b00};
      mis_n = |i_pc_target_e[1:0];
    end else if (frozen || i_stall_f) begin
      pc_n = pc_q;
    end else begin
      pc_n = i_pc_plus_4_f;
    end

    if (i_flush_d || i_pc_src_e) begin
      ifid_n = BUBBLE;
    end else if (i_stall_d) begin
      ifid_n = ifid_q;
    end else if (frozen) begin
      ifid_n = BUBBLE;
    end else begin
      ifid_n.instr = i_im_rd_f;
      ifid_n.pc    = pc_q;
      ifid_n.pc4   = i_pc_plus_4_f;
      ifid_n.valid = 1'b1;
      load         = 1'b1;
    end

    cnt_n = cnt_q + {31'd0, load};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      ifid_q  <= BUBBLE;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      ifid_q  <= ifid_n;
      mis_q   <= mis_n;
      cnt_q   <= cnt_n;
    end
  end

  assign o_pc_f        = pc_q;
  assign o_instr_d     = ifid_q.instr;
  assign o_pc_d        = ifid_q.pc;
  assign o_pc_plus_4_d = ifid_q.pc4;
  assign o_valid_d     = ifid_q.valid;
  assign o_halted      = (state_q == S_HALT);
  assign o_misalign_e  = mis_q;
  assign o_fetch_cnt   = cnt_q;

endmodule
